// File: rtl/alu_result_drain.sv
// Downstream end of the ALU result path: buffers 64-bit results in a small FIFO and replays them
// onto the 32-bit register-file write bus (LO then HI for MUL/DIV), owning the HI/LO and zero flag.
module alu_result_drain #(
    parameter int DEPTH  = 2,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_result,
    input  logic [3:0]        in_op,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_sel,
    output logic [31:0]       hi_q,
    output logic [31:0]       lo_q,
    output logic              zero_q,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;

    typedef struct packed {
        logic [63:0]       result;
        logic [3:0]        op;
        logic [DEST_W-1:0] dest;
    } entry_t;

    typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI} state_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    state_t             state, state_next;
    logic               head_wide;
    logic               push, fire, pop;

    assign head      = mem[rd_ptr];
    assign head_wide = (head.op == OP_MUL) || (head.op == OP_DIV);

    // Gating with rst_n keeps upstream stalled for the whole time reset is held.
    assign in_ready  = rst_n && (count != CNT_W'(DEPTH));
    assign busy      = (count != '0);
    assign out_valid = (state != IDLE);
    assign out_sel   = (state == BEAT_HI);
    assign out_data  = out_sel ? head.result[63:32] : head.result[31:0];
    assign out_dest  = head.dest;

    // Flush swallows any same-cycle push or write-bus handshake.
    assign push = in_valid && in_ready && !flush;
    assign fire = out_valid && out_ready && !flush;
    assign pop  = fire && (out_sel || !head_wide);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = BEAT_LO;
            BEAT_LO: if (fire) begin
                         if (head_wide)
                             state_next = BEAT_HI;
                         else
                             state_next = (count_next != '0) ? BEAT_LO : IDLE;
                     end
            BEAT_HI: if (fire) state_next = (count_next != '0) ? BEAT_LO : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; count/pointers decide validity, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{result: in_result, op: in_op, dest: in_dest};
    end

    // HI and LO are written together on the HI handshake only, so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            zero_q <= 1'b0;
        end else begin
            if (fire && out_sel) begin
                hi_q <= head.result[63:32];
                lo_q <= head.result[31:0];
            end
            if (pop)
                zero_q <= (head.result == 64'd0);
        end
    end

endmodule

// File: tb/tb_alu_result_drain.sv
// Directed bench for alu_result_drain: a negedge monitor scoreboards every write beat against
// beats queued when the matching entry was accepted; the main sequence checks flags and HI/LO.
module tb_alu_result_drain;

    localparam int DEPTH  = 2;
    localparam int DEST_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_result;
    logic [3:0]        in_op;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [DEST_W-1:0] out_dest;
    logic              out_sel;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              zero_q;
    logic              busy;

    typedef struct {
        logic [31:0]       data;
        logic [DEST_W-1:0] dest;
        logic              sel;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    alu_result_drain #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_sel   (out_sel),
        .hi_q      (hi_q),
        .lo_q      (lo_q),
        .zero_q    (zero_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] res, input logic [3:0] op, input logic [DEST_W-1:0] dest);
        in_valid  = 1'b1;
        in_result = res;
        in_op     = op;
        in_dest   = dest;
    endtask

    // Handshakes are stable at the falling edge, so the scoreboard samples there.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        beat_t e;
                        e = sb.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_dest", out_dest, e.dest);
                        check("beat_sel", out_sel, e.sel);
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back('{data: in_result[31:0], dest: in_dest, sel: 1'b0});
                    if (in_op == 4'b0101 || in_op == 4'b0110)
                        sb.push_back('{data: in_result[63:32], dest: in_dest, sel: 1'b1});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0;
        in_op = '0; in_dest = '0; out_ready = 1'b0;

        // Reset held
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_hi_lo", {hi_q, lo_q}, 0);
        check("rst_zero", zero_q, 0);
        #20 rst_n = 1'b1;
        #1 check("rel_in_ready", in_ready, 1);
        cyc();

        // 1: narrow single entry
        out_ready = 1'b1;
        drive(64'h5, 4'b0011, 4'd3);
        #1 check("t1_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        check("t1_latency_valid", out_valid, 1);
        check("t1_data", out_data, 32'd5);
        check("t1_sel", out_sel, 0);
        check("t1_dest", out_dest, 4'd3);
        cyc();
        check("t1_done_valid", out_valid, 0);
        check("t1_zero", zero_q, 0);
        check("t1_hi_lo", {hi_q, lo_q}, 0);

        // 2: wide entry with backpressure
        out_ready = 1'b0;
        drive(64'hDEAD_BEEF_1234_5678, 4'b0101, 4'd7);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_data", out_data, 32'h1234_5678);
            check("t2_hold_sel", out_sel, 0);
            check("t2_hold_valid", out_valid, 1);
            cyc();
        end
        out_ready = 1'b1;
        #1 check("t2_lo_data", out_data, 32'h1234_5678);
        cyc();
        check("t2_hi_sel", out_sel, 1);
        check("t2_hi_data", out_data, 32'hDEAD_BEEF);
        check("t2_hi_dest", out_dest, 4'd7);
        check("t2_hilo_before", {hi_q, lo_q}, 0);
        cyc();
        check("t2_hilo_after", {hi_q, lo_q}, 64'hDEAD_BEEF_1234_5678);
        check("t2_idle", out_valid, 0);

        // 3: full buffer, ordered drain, wrap and simultaneous push/pop
        out_ready = 1'b0;
        drive(64'h111, 4'b0000, 4'd1);
        cyc();
        drive(64'h222, 4'b0010, 4'd2);
        #1 check("t3_ready_one", in_ready, 1);
        cyc();
        drive(64'h333, 4'b1101, 4'd4);
        #1 check("t3_full_ready", in_ready, 0);
        check("t3_busy", busy, 1);
        cyc();
        check("t3_still_full", in_ready, 0);
        check("t3_head_hold", out_data, 32'h111);
        out_ready = 1'b1;
        cyc();
        check("t3_ready_rise", in_ready, 1);
        check("t3_second", out_data, 32'h222);
        cyc();
        in_valid = 1'b0;
        check("t3_third", out_data, 32'h333);
        check("t3_third_dest", out_dest, 4'd4);
        cyc();
        check("t3_drained", busy, 0);
        check("t3_idle", out_valid, 0);

        // 4: zero flag
        drive(64'h0, 4'b0001, 4'd5);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t4_zero_set", zero_q, 1);
        drive(64'h0000_0003_0000_0000, 4'b0110, 4'd6);
        cyc();
        in_valid = 1'b0;
        check("t4_zero_lo_pending", zero_q, 1);
        cyc();
        check("t4_zero_hi_pending", zero_q, 1);
        cyc();
        check("t4_zero_clear", zero_q, 0);
        check("t4_lo", lo_q, 32'h0);
        check("t4_hi", hi_q, 32'h3);

        // 5: flush in BEAT_HI with a same-cycle push and handshake
        drive(64'h0000_000A_0000_00B0, 4'b0101, 4'd8);
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("t5_hi_setup", hi_q, 32'hA);
        drive(64'hFFFF_0000_0000_0001, 4'b0110, 4'd9);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t5_in_hi", out_sel, 1);
        flush = 1'b1;
        drive(64'h77, 4'b0000, 4'd2);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t5_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_hi_kept", hi_q, 32'hA);
        check("t5_lo_kept", lo_q, 32'hB0);
        cyc();
        check("t5_push_dropped", out_valid, 0);
        check("t5_busy_after", busy, 0);

        // 6: asynchronous reset mid-stream
        drive(64'h0, 4'b0000, 4'd1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t6_zero_pre", zero_q, 1);
        out_ready = 1'b0;
        drive(64'h44, 4'b0000, 4'd3);
        cyc();
        drive(64'h55, 4'b0000, 4'd4);
        cyc();
        in_valid = 1'b0;
        check("t6_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_hi_lo", {hi_q, lo_q}, 0);
        check("t6_zero", zero_q, 0);
        check("t6_in_ready_held", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        check("t6_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_stale", out_valid, 0);
            cyc();
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_drain.md
Name: alu_result_drain

Overview:
- Downstream end of the ALU result path: accepts 64-bit ALU results (with op code and destination register index) over a valid/ready handshake and buffers them in a small FIFO.
- Each result goes onto the 32-bit register-file write bus as one beat, or as two beats (LO then HI) for MUL/DIV.
- Maintains the architectural HI/LO registers and a registered zero flag, decoupling the combinational ALU from register writeback.

Parameters:
- DEPTH, 2, FIFO entries; power of two, 2..8.
- DEST_W, 4, destination register index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all buffered entries and any beat in progress.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  buffer can accept an entry.
- in_result  in  64  ALU result; upper half meaningful only for MUL/DIV.
- in_op  in  4  ALU op code associated with in_result.
- in_dest  in  DEST_W  destination register index.
- out_valid  out  1  write beat valid.
- out_ready  in  1  register file accepts beat.
- out_data  out  32  beat data.
- out_dest  out  DEST_W  destination index of the current entry.
- out_sel  out  1  0 = LO/GPR beat, 1 = HI beat.
- hi_q  out  32  HI register.
- lo_q  out  32  LO register.
- zero_q  out  1  zero flag of the last fully drained entry.
- busy  out  1  at least one entry buffered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count and FSM are cleared.
  - hi_q = lo_q = 0, zero_q = 0, out_valid = 0, busy = 0, in_ready = 0 while reset is held.
  - After release, in_ready = 1.
  - Reset mid-operation drops all entries; HI/LO are not partially written.
- Push and wide ops:
  - Push occurs when in_valid && in_ready at a rising edge; the entry stored is {in_result, in_op, in_dest}.
  - An entry is wide when in_op is 4'b0101 (MUL) or 4'b0110 (DIV); all other codes, including undefined 1101-1111, are narrow.
- in_ready:
  - in_ready = (count != DEPTH).
  - It does not depend on out_ready: no push into a full buffer even when a pop happens in the same cycle.
- FSM states: IDLE, BEAT_LO, BEAT_HI.
  - IDLE: out_valid = 0. Go to BEAT_LO on the edge after count becomes nonzero.
  - BEAT_LO: out_valid = 1, out_data = head[31:0], out_sel = 0, out_dest = head dest.
    - On handshake with a narrow head: pop; next state is BEAT_LO if entries remain, else IDLE.
    - On handshake with a wide head: go to BEAT_HI without popping.
  - BEAT_HI: out_valid = 1, out_data = head[63:32], out_sel = 1, out_dest unchanged.
    - On handshake: pop; go to BEAT_LO if entries remain, else IDLE.
- Latency: an entry pushed at edge N gives out_valid = 1 in cycle N+1 when the buffer was empty. Back-to-back entries have no bubble between them.
- Output stability: while out_valid = 1 and out_ready = 0, out_data, out_dest and out_sel hold.
- HI/LO update:
  - On the BEAT_HI handshake, lo_q <= head[31:0] and hi_q <= head[63:32] in the same edge, so the update is atomic.
  - Narrow entries never modify HI/LO.
- Zero flag: on the handshake of an entry's final beat, zero_q <= (head 64-bit result == 0).
- Simultaneous push and pop: allowed when not full; count is unchanged; the pointer and FIFO write both occur.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Full when count == DEPTH; empty when count == 0.
- flush:
  - Next edge: count = 0, pointers = 0, state = IDLE, out_valid = 0.
  - A flush in BEAT_HI does not write HI/LO.
  - Flush has priority over a same-cycle push (the push is dropped) and over a same-cycle out handshake (no HI/LO/zero update).
  - hi_q, lo_q and zero_q otherwise retain their values.
- busy = (count != 0).

Test Plan:
1. Narrow single entry:
   - Stimulus: reset; push {result=64'h0000_0000_0000_0005, op=0011, dest=3}; out_ready = 1.
   - Required: one beat, out_data = 5, out_sel = 0, out_dest = 3, in the cycle after the push; zero_q = 0; hi_q and lo_q stay 0.
2. Wide entry with backpressure:
   - Stimulus: push {64'hDEAD_BEEF_1234_5678, op=0101, dest=7}; hold out_ready = 0 for 3 cycles.
   - Required: out_data stays 32'h1234_5678 with out_sel = 0.
   - Then, with out_ready = 1: beat 32'hDEAD_BEEF with out_sel = 1; hi_q = DEAD_BEEF and lo_q = 1234_5678 after the HI handshake, not before.
3. Full buffer:
   - Stimulus: out_ready = 0; push 3 entries with DEPTH = 2.
   - Required: in_ready = 0 after the second push; the third is held upstream.
   - Release out_ready: entries drain in order, and in_ready rises the cycle after the first pop.
4. Zero flag:
   - Stimulus: drain a narrow entry with result 0, then a DIV entry with 64'h0000_0003_0000_0000.
   - Required: zero_q = 1 after the first; zero_q = 0 after the DIV HI beat; lo_q = 0, hi_q = 3.
5. Flush mid-wide:
   - Stimulus: hi_q = 32'hA. In BEAT_HI of a wide entry, assert flush together with out_ready = 1 and a push.
   - Required: next cycle out_valid = 0, busy = 0, hi_q still 32'hA, the pushed entry is discarded.
6. Async reset mid-stream:
   - Stimulus: assert rst_n = 0 between edges with 2 entries buffered.
   - Required: out_valid, busy, hi_q, lo_q and zero_q go to 0 immediately, without waiting for an edge.
   - After release: in_ready = 1, and there are no stale beats.
